// File: rtl/multiplica_pkg.sv
// Shared definitions for the shift-and-add multiplier: default widths and
// FSM state encodings, also reused by the divider bench.
package multiplica_pkg;

  localparam int MLEN = 16;
  localparam int PLEN = 2 * MLEN;

  typedef enum logic [1:0] {
    ESPERA  = 2'b00,
    CALCULA = 2'b01,
    LISTO   = 2'b10
  } estado_e;

endpackage : multiplica_pkg

// File: rtl/multiplica_suma_parcial.sv
// Conditional PLEN-bit adder: adds the shifted multiplicand to the partial
// accumulator only when the current multiplier bit is set.
module suma_parcial #(
  parameter int PLEN = multiplica_pkg::PLEN
) (
  input  logic [PLEN-1:0] acumulado,
  input  logic [PLEN-1:0] sumando,
  input  logic            habilita,
  output logic [PLEN-1:0] suma
);

  import multiplica_pkg::*;

  // Pass the accumulator through, or add the shifted multiplicand to it.
  always_comb begin
    suma = acumulado;
    if (habilita) begin
      suma = acumulado + sumando;
    end else begin
      suma = acumulado;
    end
  end

endmodule : suma_parcial

// File: rtl/multiplica.sv
// Sequential unsigned multiplier, one shift-and-add step per clock.
// Operands are latched on the start edge, so input and inicie activity
// during the calculation is ignored. The product register only changes on
// the last calculation edge, so it stays stable while the result is read.
module multiplica #(
  parameter int MLEN = multiplica_pkg::MLEN,
  parameter int PLEN = multiplica_pkg::PLEN
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic [MLEN-1:0] multiplicando,
  input  logic [MLEN-1:0] multiplicador,
  input  logic            inicie,
  output logic [PLEN-1:0] producto,
  output logic            termino
);

  import multiplica_pkg::*;

  // One extra bit so the counter never wraps even when MLEN is a power of two.
  localparam int CW = $clog2(MLEN) + 1;

  estado_e         estado_r;
  estado_e         estado_s;
  logic [PLEN-1:0] mcand_r;
  logic [MLEN-1:0] mplier_r;
  logic [PLEN-1:0] acc_r;
  logic [CW-1:0]   cuenta_r;
  logic [PLEN-1:0] suma_s;
  logic            ultimo_s;

  // The last iteration is the one where the counter reaches MLEN-1.
  assign ultimo_s = (cuenta_r == CW'(MLEN - 1));

  suma_parcial #(
    .PLEN (PLEN)
  ) u_suma_parcial (
    .acumulado (acc_r),
    .sumando   (mcand_r),
    .habilita  (mplier_r[0]),
    .suma      (suma_s)
  );

  // Next-state logic: wait for start, run MLEN iterations, hold until release.
  always_comb begin
    estado_s = estado_r;
    case (estado_r)
      ESPERA: begin
        if (inicie) begin
          estado_s = CALCULA;
        end else begin
          estado_s = ESPERA;
        end
      end
      CALCULA: begin
        if (ultimo_s) begin
          estado_s = LISTO;
        end else begin
          estado_s = CALCULA;
        end
      end
      LISTO: begin
        if (inicie) begin
          estado_s = LISTO;
        end else begin
          estado_s = ESPERA;
        end
      end
      default: begin
        estado_s = ESPERA;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      estado_r <= ESPERA;
    end else begin
      estado_r <= estado_s;
    end
  end

  // Datapath: capture operands, then shift-and-add once per CALCULA edge.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mcand_r  <= {PLEN{1'b0}};
      mplier_r <= {MLEN{1'b0}};
      acc_r    <= {PLEN{1'b0}};
      cuenta_r <= {CW{1'b0}};
    end else begin
      case (estado_r)
        ESPERA: begin
          if (inicie) begin
            mcand_r  <= PLEN'(multiplicando);
            mplier_r <= multiplicador;
            acc_r    <= {PLEN{1'b0}};
            cuenta_r <= {CW{1'b0}};
          end
        end
        CALCULA: begin
          acc_r    <= suma_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cuenta_r <= cuenta_r + CW'(1);
        end
        LISTO: begin
          acc_r <= acc_r;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Product register: loaded only on the CALCULA->LISTO transition.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      producto <= {PLEN{1'b0}};
    end else if ((estado_r == CALCULA) && ultimo_s) begin
      producto <= suma_s;
    end
  end

  // Done flag: high exactly while the FSM sits in LISTO.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      termino <= 1'b0;
    end else begin
      termino <= (estado_s == LISTO);
    end
  end

endmodule : multiplica

// File: tb/tb_multiplica.sv
// Directed bench for multiplica: the stimulus pushes the hand-computed
// product on each capture edge, and an independent monitor pops and compares
// whenever termino rises.
module tb_multiplica;

  localparam int MLEN = 16;
  localparam int PLEN = 32;

  logic            clk;
  logic            reset_L;
  logic [MLEN-1:0] multiplicando;
  logic [MLEN-1:0] multiplicador;
  logic            inicie;
  logic [PLEN-1:0] producto;
  logic            termino;

  int              vectores;
  int              errores;
  logic [PLEN-1:0] exp_q[$];
  logic            term_prev;
  logic [PLEN-1:0] prod_prev;

  multiplica #(
    .MLEN (MLEN),
    .PLEN (PLEN)
  ) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .inicie        (inicie),
    .producto      (producto),
    .termino       (termino)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compare on every termino rise, and flag any product change
  // that is not accompanied by a fresh result.
  initial begin
    term_prev = 1'b0;
    prod_prev = '0;
    forever begin
      @(negedge clk);
      if (reset_L) begin
        if (termino && !term_prev) begin
          vectores++;
          if (exp_q.size() == 0) begin
            errores++;
            $display("FAIL unexpected_result: producto=%h appeared with no pending operation", producto);
          end else begin
            logic [PLEN-1:0] esperado;
            esperado = exp_q.pop_front();
            if (producto !== esperado) begin
              errores++;
              $display("FAIL product: got %h expected %h", producto, esperado);
            end
          end
        end else if (producto !== prod_prev) begin
          errores++;
          $display("FAIL product_stable: changed %h -> %h without a new result", prod_prev, producto);
        end
      end
      term_prev = termino;
      prod_prev = producto;
    end
  end

  task automatic check(input string nombre, input logic [PLEN-1:0] got, input logic [PLEN-1:0] exp);
    vectores++;
    if (got !== exp) begin
      errores++;
      $display("FAIL %s: got %h expected %h", nombre, got, exp);
    end
  endtask

  // Runs one multiplication; must be called at a negedge, returns at a negedge
  // after termino has been released, so a following call is back-to-back.
  task automatic operacion(input logic [MLEN-1:0] a, input logic [MLEN-1:0] b,
                           input logic [PLEN-1:0] esperado, input int espera_listo,
                           input bit perturba);
    int  n;
    bit  visto;
    multiplicando = a;
    multiplicador = b;
    inicie        = 1'b1;
    @(posedge clk);
    exp_q.push_back(esperado);
    n     = 0;
    visto = 1'b0;
    while (!visto && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (termino) begin
        visto = 1'b1;
      end else if (perturba) begin
        multiplicando = 16'd2;
        multiplicador = 16'd2;
        inicie        = ~inicie;
      end
    end
    check("latency_edges", PLEN'(n), PLEN'(MLEN));
    inicie = 1'b1;
    for (int k = 0; k < espera_listo; k++) begin
      @(negedge clk);
      check("termino_held", {31'd0, termino}, 32'd1);
      check("producto_held", producto, esperado);
    end
    inicie = 1'b0;
    @(negedge clk);
    check("termino_release", {31'd0, termino}, 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    bit limpio;
    vectores      = 0;
    errores       = 0;
    reset_L       = 1'b0;
    inicie        = 1'b0;
    multiplicando = '0;
    multiplicador = '0;
    #1;
    check("reset_producto", producto, 32'd0);
    check("reset_termino", {31'd0, termino}, 32'd0);
    repeat (3) @(negedge clk);
    reset_L = 1'b1;
    @(negedge clk);
    check("idle_termino", {31'd0, termino}, 32'd0);

    operacion(16'd3,      16'd5,      32'h0000_000F, 3, 1'b0);
    operacion(16'hFFFF,   16'hFFFF,   32'hFFFE_0001, 1, 1'b0);
    @(negedge clk);
    operacion(16'd0,      16'h1234,   32'h0000_0000, 1, 1'b0);
    operacion(16'h1234,   16'd0,      32'h0000_0000, 1, 1'b0);
    operacion(16'd7,      16'd9,      32'd63,        1, 1'b1);
    operacion(16'd100,    16'd200,    32'd20000,     1, 1'b0);
    operacion(16'h8000,   16'd2,      32'h0001_0000, 2, 1'b0);

    // Abort mid-calculation with reset at CALCULA edge 8.
    multiplicando = 16'd11;
    multiplicador = 16'd13;
    inicie        = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    reset_L = 1'b0;
    #1;
    check("abort_producto", producto, 32'd0);
    check("abort_termino", {31'd0, termino}, 32'd0);
    inicie = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    limpio  = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (termino) limpio = 1'b0;
    end
    check("abort_no_termino", {31'd0, limpio}, 32'd1);
    check("abort_producto_after", producto, 32'd0);

    // A fresh start after the abort still works.
    operacion(16'd12,     16'd12,     32'd144,       1, 1'b0);
    @(negedge clk);
    check("scoreboard_drained", PLEN'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectores, errores);
    $finish;
  end

endmodule : tb_multiplica
